demosaic_mul_arbiter: RTL and testbench
=======================================

Name: demosaic_mul_arbiter

Overview:
- Shares one pipelined unsigned 13x11 multiplier (one DSP48 slice) among NUM_REQ requesters in the demosaic datapath, such as the per-channel white-balance and gain stages.
- Round-robin arbitration with a valid/ready handshake on each request port.
- Accepted operations carry a requester tag through the pipeline; a single response port returns the product with that tag.
- Backpressure on the response port stalls the whole pipeline.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- A_WIDTH, 13: operand A width, unsigned.
- B_WIDTH, 11: operand B width, unsigned.
- P_WIDTH, 24: product width. Must be <= A_WIDTH+B_WIDTH; the low P_WIDTH bits are kept.
- MUL_STAGES, 3: pipeline depth from issue register to response register, 1..4.
- ID_WIDTH, 2: tag width. Must be >= clog2(NUM_REQ).

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  packed operand A; requester i occupies bits [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  packed operand B, same packing.
- rsp_valid  out  1  product valid.
- rsp_id  out  ID_WIDTH  index of the requester that issued the product.
- rsp_p  out  P_WIDTH  product.
- rsp_ready  in  1  consumer accepts the product.

Behaviour:
- Reset is asynchronous on ap_rst_n low. On reset:
  - rsp_valid=0, rsp_id=0, rsp_p=0.
  - All stage valid bits=0.
  - Round-robin pointer rr_ptr=0.
- req_ready is combinational. While ap_rst_n is low, req_ready=0.
- advance = !rsp_valid || rsp_ready. Every pipeline stage shifts only when advance=1; otherwise all stages hold.
- Arbitration is combinational:
  - grant = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - req_ready[grant] = advance. All other req_ready bits are 0.
  - If no req_valid is set, req_ready=0.
- Acceptance occurs when req_valid[i] && req_ready[i] at a rising edge. On acceptance:
  - Stage 1 captures a, b, id=i, valid=1.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- If advance=1 with nothing granted, stage 1 captures valid=0 (a bubble). rr_ptr is unchanged.
- Datapath:
  - Stage 1 registers the operands.
  - Products are full-width unsigned, A_WIDTH+B_WIDTH bits, with no signedness.
  - Later stages register the product, truncated to P_WIDTH at the final stage.
  - Stage MUL_STAGES drives rsp_valid/rsp_id/rsp_p.
- Latency: a request accepted at edge T with no stall asserts rsp_valid after edge T+MUL_STAGES-1. For MUL_STAGES=1, this is the same edge as acceptance. Each stall cycle adds one.
- Throughput: one op per cycle when rsp_ready stays high.
- Ordering: responses appear in acceptance order. Tags are never reordered or dropped.
- Stall (rsp_valid=1, rsp_ready=0):
  - rsp_* outputs hold stable.
  - req_ready=0 on all ports.
  - In-flight ops are retained.
- Simultaneous response drain and new accept in one cycle is legal and required for full rate.
- Fairness: a continuously asserted request is granted within NUM_REQ accepts.
- Requesters must hold req_a/req_b stable while req_valid=1 and not yet accepted. Deasserting req_valid before acceptance is permitted and causes no issue.
- Reset mid-operation discards all in-flight ops immediately. No response is produced for them.

Optional Feature:
- Macro: DEMOSAIC_MUL_ARB_STATS_EN.
- When defined, adds two outputs:
  - stat_issue (out, 16): counts accepted ops.
  - stat_stall (out, 16): counts cycles with rsp_valid=1 && rsp_ready=0.
- Both counters reset to 0, saturate at 16'hFFFF, and are reset only by ap_rst_n.
- When undefined, neither port nor counter exists. Function is otherwise identical.

Test Plan:
- Single request, MUL_STAGES=3, rsp_ready=1. req0 a=13'h1FFF, b=11'h7FF, accepted at edge 0 -> rsp_valid=1 after edge 2 with rsp_id=0, rsp_p=24'hFFD801, held one cycle.
- Fairness, NUM_REQ=4. All four req_valid held high with a=i+1, b=10, rsp_ready=1 -> grant order 0,1,2,3,0,... and rsp_id sequence 0,1,2,3 with rsp_p 10,20,30,40. One accept per cycle.
- Round-robin pointer. Accept req2 alone, then raise req1 and req3 together -> req3 granted first, then req1.
- Backpressure. Stream 6 ops from req1 and drop rsp_ready for 4 cycles mid-stream -> rsp_* stable during the stall, req_ready=0, all 6 products delivered in order with none lost or duplicated. With DEMOSAIC_MUL_ARB_STATS_EN: stat_issue=6, stat_stall=4.
- Reset mid-flight. Pull ap_rst_n low asynchronously with 3 ops in flight -> rsp_valid falls immediately and req_ready=0. After release, no stale response appears and the next accepted op returns with the correct latency.
- Bubbles. req_valid pulses every third cycle -> rsp_valid pulses every third cycle with latency exactly MUL_STAGES-1 edges after acceptance.

Source files
------------

// File: rtl/demosaic_mul_arbiter.sv
// Purpose: round-robin share of one pipelined unsigned A x B multiplier among NUM_REQ requesters, tagged responses.
// Latency: response valid MUL_STAGES-1 edges after the accept edge (same edge when MUL_STAGES=1), plus one per stall cycle.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and forces req_ready low; optional counters via DEMOSAIC_MUL_ARB_STATS_EN.
module demosaic_mul_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int A_WIDTH    = 13,
    parameter int B_WIDTH    = 11,
    parameter int P_WIDTH    = 24,
    parameter int MUL_STAGES = 3,
    parameter int ID_WIDTH   = 2
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
    output logic                        rsp_valid,
    output logic [ID_WIDTH-1:0]         rsp_id,
    output logic [P_WIDTH-1:0]          rsp_p,
`ifdef DEMOSAIC_MUL_ARB_STATS_EN
    output logic [15:0]                 stat_issue,
    output logic [15:0]                 stat_stall,
`endif
    input  logic                        rsp_ready
);

    localparam int FW    = A_WIDTH + B_WIDTH;
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    rr_nxt;
    logic [PTR_W-1:0]    scan_idx;
    logic [PTR_W-1:0]    grant_idx;
    logic                grant_ok;
    logic                advance;
    logic                accept;
    logic [A_WIDTH-1:0]  sel_a;
    logic [B_WIDTH-1:0]  sel_b;
    logic [FW-1:0]       rsp_full;
    logic                st_vld [1:MUL_STAGES];
    logic [ID_WIDTH-1:0] st_id  [1:MUL_STAGES];

    // Full-width unsigned product; operands zero-extended so no bits are lost.
    function automatic logic [FW-1:0] umul(input logic [A_WIDTH-1:0] a, input logic [B_WIDTH-1:0] b);
        return {{B_WIDTH{1'b0}}, a} * {{A_WIDTH{1'b0}}, b};
    endfunction

    // Wrap a scan position back into 0..NUM_REQ-1.
    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return (v >= NUM_REQ) ? PTR_W'(v - NUM_REQ) : PTR_W'(v);
    endfunction

    // The whole pipeline moves together whenever the response register is free or being drained.
    assign advance = !rsp_valid || rsp_ready;
    assign accept  = grant_ok && advance;
    assign rr_nxt  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    // Round-robin scan starting at rr_ptr; first active requester wins.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = wrap_idx(int'(rr_ptr) + k);
            if (!grant_ok && req_valid[scan_idx]) begin
                grant_ok  = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    // Operand mux for the granted port, plus the one-hot ready (held low during reset).
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_a = req_a[i*A_WIDTH +: A_WIDTH];
                sel_b = req_b[i*B_WIDTH +: B_WIDTH];
            end
        end
        if (ap_rst_n && accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Valid/tag shift chain and round-robin pointer; a non-grant cycle inserts a bubble.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
            for (int k = 1; k <= MUL_STAGES; k++) begin
                st_vld[k] <= 1'b0;
                st_id[k]  <= '0;
            end
        end else if (advance) begin
            st_vld[1] <= accept;
            st_id[1]  <= ID_WIDTH'(grant_idx);
            for (int k = 2; k <= MUL_STAGES; k++) begin
                st_vld[k] <= st_vld[k-1];
                st_id[k]  <= st_id[k-1];
            end
            if (accept) begin
                rr_ptr <= rr_nxt;
            end
        end
    end

    generate
        if (MUL_STAGES == 1) begin : g_direct
            logic [FW-1:0] prod_q;

            // Single stage: multiply straight into the response register.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    prod_q <= '0;
                end else if (advance) begin
                    prod_q <= umul(sel_a, sel_b);
                end
            end

            assign rsp_full = prod_q;
        end else begin : g_piped
            logic [A_WIDTH-1:0] op_a;
            logic [B_WIDTH-1:0] op_b;
            logic [FW-1:0]      prod_q [2:MUL_STAGES];

            // Operand register in stage 1, product registered from stage 2 onward.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    op_a <= '0;
                    op_b <= '0;
                    for (int k = 2; k <= MUL_STAGES; k++) begin
                        prod_q[k] <= '0;
                    end
                end else if (advance) begin
                    op_a      <= sel_a;
                    op_b      <= sel_b;
                    prod_q[2] <= umul(op_a, op_b);
                    for (int k = 3; k <= MUL_STAGES; k++) begin
                        prod_q[k] <= prod_q[k-1];
                    end
                end
            end

            assign rsp_full = prod_q[MUL_STAGES];
        end
    endgenerate

    assign rsp_valid = st_vld[MUL_STAGES];
    assign rsp_id    = st_id[MUL_STAGES];
    assign rsp_p     = rsp_full[P_WIDTH-1:0];

`ifdef DEMOSAIC_MUL_ARB_STATS_EN
    // Saturating counters of accepted ops and of stalled response cycles.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            stat_issue <= '0;
            stat_stall <= '0;
        end else begin
            if (accept && stat_issue != 16'hFFFF) begin
                stat_issue <= stat_issue + 16'd1;
            end
            if (rsp_valid && !rsp_ready && stat_stall != 16'hFFFF) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demosaic_mul_arbiter.sv
// Purpose: randomized and directed checks of demosaic_mul_arbiter against a queue-based reference.
// Latency: reference tracks each op's age in advancing edges; visible at age MUL_STAGES-1.
// Backpressure: random rsp_ready drops; reference predicts grants, stalls and response order.
module tb_demosaic_mul_arbiter;

    localparam int N  = 4;
    localparam int AW = 13;
    localparam int BW = 11;
    localparam int PW = 24;
    localparam int MS = 3;
    localparam int IW = 2;
    localparam longint PMASK = (longint'(1) << PW) - 1;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic            rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic [PW-1:0]   rsp_p;
    logic            rsp_ready;
`ifdef DEMOSAIC_MUL_ARB_STATS_EN
    logic [15:0]     stat_issue;
    logic [15:0]     stat_stall;
`endif

    demosaic_mul_arbiter #(
        .NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW), .P_WIDTH(PW), .MUL_STAGES(MS), .ID_WIDTH(IW)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst_n(ap_rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_p(rsp_p),
`ifdef DEMOSAIC_MUL_ARB_STATS_EN
        .stat_issue(stat_issue),
        .stat_stall(stat_stall),
`endif
        .rsp_ready(rsp_ready)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct { int id; longint p; int age; } ent_t;
    typedef struct { int id; longint p; int cyc; } rsp_t;

    int        errors = 0;
    int        checks = 0;
    int        a_v [N];
    int        b_v [N];
    ent_t      q [$];
    rsp_t      rlog [$];
    int        acc_log [$];
    int        mrr = 0;
    int        m_acc = -1;
    int        cyc = 0;
    int        stalls = 0;
    int        accepts = 0;
    logic [N-1:0] obs_rdy;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*AW +: AW] = AW'(a_v[i]);
            req_b[i*BW +: BW] = BW'(b_v[i]);
        end
    endtask

    // One clock: check DUT against the reference at the falling edge, then advance the reference
    // through the coming rising edge. Called at posedge+1..+2, returns at posedge+1.
    task automatic cycle();
        logic         exp_v;
        logic         adv;
        int           g;
        int           idx;
        logic [N-1:0] exp_rdy;
        pack();
        @(negedge ap_clk);
        exp_v = (q.size() > 0) && (q[0].age == MS - 1);
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        if (exp_v) begin
            chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
            chk("rsp_p", 64'(rsp_p), 64'(q[0].p));
        end
        adv = !exp_v || rsp_ready;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (mrr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        exp_rdy = (g >= 0 && adv) ? N'(1 << g) : '0;
        obs_rdy = req_ready;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (rsp_valid && rsp_ready) rlog.push_back('{int'(rsp_id), longint'(rsp_p), cyc});
        if (rsp_valid && !rsp_ready) stalls++;
        if (exp_v && rsp_ready) q.delete(0);
        if (adv) foreach (q[i]) q[i].age++;
        m_acc = -1;
        if (g >= 0 && adv) begin
            q.push_back('{g, (longint'(a_v[g]) * longint'(b_v[g])) & PMASK, 0});
            mrr = (g + 1) % N;
            m_acc = g;
            acc_log.push_back(cyc);
            accepts++;
        end
        cyc++;
        @(posedge ap_clk);
        #1;
    endtask

    // Asynchronous reset between edges; outputs must drop at once and in-flight ops vanish.
    task automatic do_reset();
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        q.delete();
        mrr = 0;
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int acc0;
        int phase_acc;
        for (int i = 0; i < N; i++) begin
            a_v[i] = 0;
            b_v[i] = 0;
        end
        pack();
        rsp_ready = 1'b1;
        req_valid = '1;
        ap_rst_n  = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_id", 64'(rsp_id), 64'd0);
        chk("reset_rsp_p", 64'(rsp_p), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(posedge ap_clk);
        #2;
        ap_rst_n = 1'b1;

        // Single max-operand op: visible right after edge 2, held for one cycle.
        a_v[0] = 13'h1FFF;
        b_v[0] = 11'h7FF;
        req_valid = 4'b0001;
        cycle();
        chk("t1_accept", 64'(obs_rdy), 64'd1);
        req_valid = '0;
        cycle();
        cycle();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t1_rsp_id", 64'(rsp_id), 64'd0);
        chk("t1_rsp_p", 64'(rsp_p), 64'hFFD801);
        cycle();
        chk("t1_rsp_gone", 64'(rsp_valid), 64'd0);
        repeat (2) cycle();

        // Fairness: all requesters held high.
        do_reset();
        rlog.delete();
        for (int i = 0; i < N; i++) begin
            a_v[i] = i + 1;
            b_v[i] = 10;
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("fair_grant", 64'(obs_rdy), 64'(1 << (k % N)));
        end
        req_valid = '0;
        repeat (4) cycle();
        chk("fair_count", 64'(rlog.size()), 64'd8);
        for (int k = 0; k < 4; k++) begin
            chk("fair_id", 64'(rlog[k].id), 64'(k));
            chk("fair_p", 64'(rlog[k].p), 64'(10 * (k + 1)));
        end

        // Round-robin pointer: after req2, req3 wins over req1.
        do_reset();
        req_valid = 4'b0100;
        cycle();
        chk("rr_first", 64'(obs_rdy), 64'b0100);
        req_valid = 4'b1010;
        cycle();
        chk("rr_second", 64'(obs_rdy), 64'b1000);
        req_valid = 4'b0010;
        cycle();
        chk("rr_third", 64'(obs_rdy), 64'b0010);
        req_valid = '0;
        repeat (4) cycle();

        // Backpressure: 6 ops from req1 with a 4-cycle rsp_ready drop mid-stream.
        do_reset();
        rlog.delete();
        stalls = 0;
        n = 0;
        a_v[1] = 100;
        b_v[1] = 7;
        req_valid = 4'b0010;
        for (int c = 0; c < 24; c++) begin
            rsp_ready = !(c >= 4 && c < 8);
            cycle();
            if (c >= 4 && c < 8) chk("bp_ready_low", 64'(obs_rdy), 64'd0);
            if (m_acc == 1) begin
                n++;
                a_v[1] = 100 + n;
                if (n == 6) req_valid = '0;
            end
        end
        rsp_ready = 1'b1;
        chk("bp_count", 64'(rlog.size()), 64'd6);
        chk("bp_stalls", 64'(stalls), 64'd4);
        for (int k = 0; k < 6 && k < rlog.size(); k++) begin
            chk("bp_id", 64'(rlog[k].id), 64'd1);
            chk("bp_p", 64'(rlog[k].p), 64'((100 + k) * 7));
        end
`ifdef DEMOSAIC_MUL_ARB_STATS_EN
        chk("stat_issue", 64'(stat_issue), 64'd6);
        chk("stat_stall", 64'(stat_stall), 64'd4);
`endif

        // Reset with ops in flight, then one op with clean latency.
        do_reset();
        for (int i = 0; i < N; i++) begin
            a_v[i] = $urandom_range(0, 8191);
            b_v[i] = $urandom_range(0, 2047);
        end
        req_valid = '1;
        repeat (3) cycle();
        do_reset();
        rlog.delete();
        req_valid = 4'b0001;
        cycle();
        chk("mid_rst_accept", 64'(obs_rdy), 64'd1);
        acc0 = cyc - 1;
        req_valid = '0;
        repeat (6) cycle();
        chk("mid_rst_count", 64'(rlog.size()), 64'd1);
        // Accepted at the end of cycle acc0, visible after MS-1 more edges, sampled one cycle later.
        if (rlog.size() > 0) chk("mid_rst_lat", 64'(rlog[0].cyc - acc0), 64'(MS));

        // Bubbles: a request every third cycle.
        do_reset();
        rlog.delete();
        acc_log.delete();
        for (int c = 0; c < 18; c++) begin
            req_valid = (c % 3 == 0) ? 4'b0001 : 4'b0000;
            a_v[0] = c + 1;
            b_v[0] = 5;
            cycle();
        end
        req_valid = '0;
        repeat (4) cycle();
        chk("bub_rsp_count", 64'(rlog.size()), 64'd6);
        chk("bub_acc_count", 64'(acc_log.size()), 64'd6);
        for (int j = 0; j < 6 && j < rlog.size() && j < acc_log.size(); j++) begin
            chk("bub_lat", 64'(rlog[j].cyc - acc_log[j]), 64'(MS));
            if (j > 0) chk("bub_spacing", 64'(rlog[j].cyc - rlog[j-1].cyc), 64'd3);
        end

        // Random traffic against the reference.
        do_reset();
        rlog.delete();
        phase_acc = accepts;
        req_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            cycle();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && m_acc != i) begin
                    if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = $urandom_range(0, 1) == 1;
                    a_v[i] = $urandom_range(0, 8191);
                    b_v[i] = $urandom_range(0, 2047);
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (8) cycle();
        chk("rand_all_delivered", 64'(rlog.size()), 64'(accepts - phase_acc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
